flip_flop: RTL and testbench



---
 rtl/flip_flop.sv | 56 +++++
 tb/tb_flip_flop.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/flip_flop.sv
// Registered key-to-LED path: a STAGES-deep register pipeline from Key_in to led_out,
// with registered one-clock pulses reporting led_out rising and falling transitions.
module flip_flop #(
  parameter int       STAGES  = 1,
  parameter logic     RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic Key_in,
  output logic led_out,
  output logic led_rise,
  output logic led_fall
);

  generate
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("flip_flop: STAGES must be in 1..8");
    end
  endgenerate

  logic [STAGES-1:0] stage_p0;
  logic              led_q_p1;
  logic              rise_p1;
  logic              fall_p1;

  // Capture pipeline: Key_in enters stage 0, led_out taps the last stage
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stage_p0 <= {STAGES{RST_VAL}};
    end else begin
      stage_p0[0] <= Key_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_p0[i] <= stage_p0[i-1];
      end
    end
  end

  assign led_out = stage_p0[STAGES-1];

  // Edge stage: compare led_out against its one-clock-old copy
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_q_p1 <= RST_VAL;
      rise_p1  <= 1'b0;
      fall_p1  <= 1'b0;
    end else begin
      led_q_p1 <= led_out;
      rise_p1  <= led_out & ~led_q_p1;
      fall_p1  <= ~led_out & led_q_p1;
    end
  end

  assign led_rise = rise_p1;
  assign led_fall = fall_p1;

endmodule

// File: tb/tb_flip_flop.sv
// Directed bench for flip_flop: one-stage and three-stage instances share clock, reset and key.
module tb_flip_flop;

  logic clk = 1'b0;
  logic rst;
  logic key;
  logic led1, rise1, fall1;
  logic led3, rise3, fall3;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  flip_flop #(.STAGES(1), .RST_VAL(1'b0)) dut1 (
    .sys_clk (clk),
    .sys_rst (rst),
    .Key_in  (key),
    .led_out (led1),
    .led_rise(rise1),
    .led_fall(fall1)
  );

  flip_flop #(.STAGES(3), .RST_VAL(1'b0)) dut3 (
    .sys_clk (clk),
    .sys_rst (rst),
    .Key_in  (key),
    .led_out (led3),
    .led_rise(rise3),
    .led_fall(fall3)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       vec [5];
    logic       rkey;
    int         nxt;

    vec[0] = 1'b1; vec[1] = 1'b0; vec[2] = 1'b1; vec[3] = 1'b1; vec[4] = 1'b0;

    // Reset for 2 clocks with key held high: reset must win
    rst = 1'b1;
    key = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_led1", led1, 1'b0);
      check("reset_rise1", rise1, 1'b0);
      check("reset_fall1", fall1, 1'b0);
      check("reset_led3", led3, 1'b0);
    end

    // Basic capture, one-clock latency
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key = vec[i];
      @(negedge clk);
      check("capture_led1", led1, vec[i]);
    end

    // Random run with a mid-run reset
    for (int i = 0; i < 200; i++) begin
      if (i == 100 || i == 101) begin
        rst = 1'b1;
        key = 1'b1;
        @(negedge clk);
        check("midreset_led1", led1, 1'b0);
        check("midreset_rise1", rise1, 1'b0);
      end else begin
        rst  = 1'b0;
        rkey = 1'($urandom_range(0, 1));
        key  = rkey;
        @(negedge clk);
        check("random_led1", led1, rkey);
        check("random_not_both", rise1 & fall1, 1'b0);
      end
    end

    // Edge pulses: reset, settle low, key high for 3 clocks, then low
    rst = 1'b1;
    key = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("edge_idle_led1", led1, 1'b0);
    check("edge_idle_rise1", rise1, 1'b0);
    key = 1'b1;
    @(negedge clk);
    check("edge_t1_led1", led1, 1'b1);
    check("edge_t1_rise1", rise1, 1'b0);
    @(negedge clk);
    check("edge_t2_led1", led1, 1'b1);
    check("edge_t2_rise1", rise1, 1'b1);
    check("edge_t2_fall1", fall1, 1'b0);
    @(negedge clk);
    check("edge_t3_led1", led1, 1'b1);
    check("edge_t3_rise1", rise1, 1'b0);
    key = 1'b0;
    @(negedge clk);
    check("edge_t4_led1", led1, 1'b0);
    check("edge_t4_rise1", rise1, 1'b0);
    check("edge_t4_fall1", fall1, 1'b0);
    @(negedge clk);
    check("edge_t5_fall1", fall1, 1'b1);
    check("edge_t5_rise1", rise1, 1'b0);
    @(negedge clk);
    check("edge_t6_fall1", fall1, 1'b0);

    // Three-stage pipeline: single-clock pulse appears 3 edges after capture
    rst = 1'b1;
    key = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("s3_idle_led3", led3, 1'b0);
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
    check("s3_e1_led3", led3, 1'b0);
    @(negedge clk);
    check("s3_e2_led3", led3, 1'b0);
    @(negedge clk);
    check("s3_e3_led3", led3, 1'b1);
    check("s3_e3_rise3", rise3, 1'b0);
    @(negedge clk);
    check("s3_e4_led3", led3, 1'b0);
    check("s3_e4_rise3", rise3, 1'b1);
    @(negedge clk);
    check("s3_e5_led3", led3, 1'b0);
    check("s3_e5_fall3", fall3, 1'b1);
    check("s3_e5_rise3", rise3, 1'b0);
    @(negedge clk);
    check("s3_e6_fall3", fall3, 1'b0);

    // Reset mid-flight discards three-stage contents
    key = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("s3_flush_led3", led3, 1'b0);
    rst = 1'b0;
    key = 1'b0;
    @(negedge clk);
    check("s3_flush2_led3", led3, 1'b0);
    @(negedge clk);
    check("s3_flush3_led3", led3, 1'b0);
    nxt = checks;

    $display("Simulation finished: %0d checks, %0d errors", nxt, errors);
    $finish;
  end

endmodule
